// File: rtl/axis_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : axis_burst_gen
// Brief    : AXI-Stream burst source with deterministic data pattern, TLAST
//            framing, programmable inter-burst gaps, graceful stop and
//            saturating beat/stall counters for throughput measurement.
// Options  : define AXIS_BURST_GEN_LFSR_EN to advance the pattern as a 32-bit
//            Galois LFSR (taps 0x80200003) instead of a +1 counter.
// Revision : 1.0 - initial release
// ============================================================================
module axis_burst_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [15:0]           burst_len,
    input  logic [7:0]            num_bursts,
    input  logic [7:0]            gap_cycles,
    input  logic [31:0]           seed,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  beats_sent,
    output logic [CNT_WIDTH-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

`ifdef AXIS_BURST_GEN_LFSR_EN
    localparam logic [31:0] C_LFSR_TAPS = 32'h8020_0003;

    // Galois LFSR step: shift right, fold taps in when the bit shifted out is 1
    function automatic logic [31:0] pat_next(input logic [31:0] p);
        return p[0] ? ((p >> 1) ^ C_LFSR_TAPS) : (p >> 1);
    endfunction

    // The all-zero state is a lockup state for the LFSR, so it is never loaded
    function automatic logic [31:0] pat_load(input logic [31:0] s);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction
`else
    function automatic logic [31:0] pat_next(input logic [31:0] p);
        return p + 32'd1;
    endfunction

    function automatic logic [31:0] pat_load(input logic [31:0] s);
        return s;
    endfunction
`endif

    state_t                 state_q, state_d;
    logic [31:0]            pattern_q, pattern_d;
    logic [15:0]            len_q, len_d;
    logic [15:0]            beat_idx_q, beat_idx_d;
    logic [7:0]             nb_q, nb_d;
    logic [7:0]             bursts_done_q, bursts_done_d;
    logic [7:0]             gap_q, gap_d;
    logic [7:0]             gap_ctr_q, gap_ctr_d;
    logic                   stop_pend_q, stop_pend_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [CNT_WIDTH-1:0]   beats_q, beats_d;
    logic [CNT_WIDTH-1:0]   stalls_q, stalls_d;

    logic                   w_hs;
    logic                   w_stop_eff;
    logic [7:0]             w_bursts_inc;

    // A stop arriving in the same cycle as the final beat already ends the run
    assign w_hs         = tvalid_q & m_tready;
    assign w_stop_eff   = stop_pend_q | stop;
    assign w_bursts_inc = bursts_done_q + 8'd1;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d       = state_q;
        pattern_d     = pattern_q;
        len_d         = len_q;
        beat_idx_d    = beat_idx_q;
        nb_d          = nb_q;
        bursts_done_d = bursts_done_q;
        gap_d         = gap_q;
        gap_ctr_d     = gap_ctr_q;
        stop_pend_d   = stop_pend_q;
        beats_d       = beats_q;
        stalls_d      = stalls_q;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (burst_len != 16'd0)) begin
                    len_d         = burst_len;
                    nb_d          = num_bursts;
                    gap_d         = gap_cycles;
                    pattern_d     = pat_load(seed);
                    beat_idx_d    = 16'd0;
                    bursts_done_d = 8'd0;
                    stop_pend_d   = 1'b0;
                    beats_d       = '0;
                    stalls_d      = '0;
                    state_d       = S_SEND;
                end
            end

            S_SEND: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (!m_tready && (stalls_q != C_CNT_MAX)) begin
                    stalls_d = stalls_q + C_CNT_ONE;
                end
                if (w_hs) begin
                    if (beats_q != C_CNT_MAX) begin
                        beats_d = beats_q + C_CNT_ONE;
                    end
                    pattern_d = pat_next(pattern_q);
                    if (tlast_q) begin
                        beat_idx_d    = 16'd0;
                        bursts_done_d = w_bursts_inc;
                        if (w_stop_eff || ((nb_q != 8'd0) && (w_bursts_inc == nb_q))) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else if (gap_q == 8'd0) begin
                            state_d = S_SEND;
                        end else begin
                            gap_ctr_d = gap_q;
                            state_d   = S_GAP;
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + 16'd1;
                    end
                end
            end

            S_GAP: begin
                if (w_stop_eff) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (gap_ctr_q <= 8'd1) begin
                    state_d = S_SEND;
                end else begin
                    gap_ctr_d = gap_ctr_q - 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        tvalid_d = (state_d == S_SEND);
        busy_d   = (state_d != S_IDLE);
        tlast_d  = (state_d == S_SEND) && (beat_idx_d == (len_d - 16'd1));
    end

    // State, datapath and output registers; reset abandons any run in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pattern_q     <= 32'd0;
            len_q         <= 16'd0;
            beat_idx_q    <= 16'd0;
            nb_q          <= 8'd0;
            bursts_done_q <= 8'd0;
            gap_q         <= 8'd0;
            gap_ctr_q     <= 8'd0;
            stop_pend_q   <= 1'b0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            beats_q       <= '0;
            stalls_q      <= '0;
        end else begin
            state_q       <= state_d;
            pattern_q     <= pattern_d;
            len_q         <= len_d;
            beat_idx_q    <= beat_idx_d;
            nb_q          <= nb_d;
            bursts_done_q <= bursts_done_d;
            gap_q         <= gap_d;
            gap_ctr_q     <= gap_ctr_d;
            stop_pend_q   <= stop_pend_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            beats_q       <= beats_d;
            stalls_q      <= stalls_d;
        end
    end

    // Fit the 32-bit pattern register onto the configured data width
    generate
        if (DATA_WIDTH > 32) begin : g_zext
            assign m_tdata = {{(DATA_WIDTH-32){1'b0}}, pattern_q};
        end else if (DATA_WIDTH == 32) begin : g_same
            assign m_tdata = pattern_q;
        end else begin : g_trunc
            assign m_tdata = pattern_q[DATA_WIDTH-1:0];
        end
    endgenerate

    assign m_tvalid     = tvalid_q;
    assign m_tlast      = tlast_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign beats_sent   = beats_q;
    assign stall_cycles = stalls_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_burst_gen
// Brief    : Scoreboard bench for axis_burst_gen. Stimulus pushes expected
//            beats; a negedge monitor compares every presented beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_burst_gen;

    localparam int DW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [15:0]   burst_len = 16'd0;
    logic [7:0]    num_bursts = 8'd0;
    logic [7:0]    gap_cycles = 8'd0;
    logic [31:0]   seed = 32'd0;
    logic          m_tready = 1'b0;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          busy;
    logic          done;
    logic [CW-1:0] beats_sent;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    axis_burst_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .burst_len    (burst_len),
        .num_bursts   (num_bursts),
        .gap_cycles   (gap_cycles),
        .seed         (seed),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tdata      (m_tdata),
        .m_tlast      (m_tlast),
        .busy         (busy),
        .done         (done),
        .beats_sent   (beats_sent),
        .stall_cycles (stall_cycles)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    gaps_q[$];
    int    tests_run = 0;
    int    fails = 0;
    int    done_cnt = 0;
    int    idle_run = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

`ifdef AXIS_BURST_GEN_LFSR_EN
    function automatic logic [31:0] m_next(input logic [31:0] p);
        return p[0] ? ((p >> 1) ^ 32'h8020_0003) : (p >> 1);
    endfunction
    function automatic logic [31:0] m_load(input logic [31:0] s);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction
`else
    function automatic logic [31:0] m_next(input logic [31:0] p);
        return p + 32'd1;
    endfunction
    function automatic logic [31:0] m_load(input logic [31:0] s);
        return s;
    endfunction
`endif

    // Queue the beats a run of nb bursts of len beats must produce
    task automatic push_run(input logic [31:0] sd, input int len, input int nb);
        logic [31:0] p;
        beat_t       e;
        p = m_load(sd);
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < len; i++) begin
                e.data = p;
                e.last = (i == len - 1);
                sb.push_back(e);
                p = m_next(p);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(input logic [31:0] sd, input logic [15:0] len,
                      input logic [7:0] nb, input logic [7:0] gp);
        seed       = sd;
        burst_len  = len;
        num_bursts = nb;
        gap_cycles = gp;
        start      = 1'b1;
        cyc(1);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, {63'd0, ok}, 64'd1);
        cyc(1);
    endtask

    // Monitor: compare every presented beat with the scoreboard head; a stalled
    // beat is compared every cycle, which also proves it is held stable
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (m_tvalid) begin
                if (idle_run > 0) begin
                    gaps_q.push_back(idle_run);
                    idle_run = 0;
                end
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {32'd0, m_tdata}, 64'hDEAD);
                end else begin
                    chk("tdata", {32'd0, m_tdata}, {32'd0, sb[0].data});
                    chk("tlast", {63'd0, m_tlast}, {63'd0, sb[0].last});
                    if (m_tready) void'(sb.pop_front());
                end
            end else if (busy) begin
                idle_run++;
            end
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("rst_busy",   {63'd0, busy},     64'd0);
        chk("rst_done",   {63'd0, done},     64'd0);
        chk("rst_tdata",  {32'd0, m_tdata},  64'd0);
        chk("rst_beats",  {32'd0, beats_sent}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(2);

        // Basic burst with exact latency and done timing
        done_cnt = 0;
        m_tready = 1'b1;
        chk("t1_idle_tvalid", {63'd0, m_tvalid}, 64'd0);
        push_run(32'h10, 4, 1);
        go(32'h10, 16'd4, 8'd1, 8'd0);
        chk("t1_latency", {63'd0, m_tvalid}, 64'd1);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        cyc(4);
        chk("t1_done_timing", {63'd0, done}, 64'd1);
        chk("t1_beats", {32'd0, beats_sent}, 64'd4);
        chk("t1_stalls", {32'd0, stall_cycles}, 64'd0);
        cyc(2);
        chk("t1_done_cnt", done_cnt, 64'd1);
        chk("t1_sb_empty", sb.size(), 64'd0);
        chk("t1_busy_end", {63'd0, busy}, 64'd0);

        // Backpressure while 0x11 is presented
        done_cnt = 0;
        push_run(32'h10, 4, 1);
        go(32'h10, 16'd4, 8'd1, 8'd0);
        cyc(1);
        m_tready = 1'b0;
        cyc(3);
        m_tready = 1'b1;
        wait_done("t2");
        chk("t2_stalls", {32'd0, stall_cycles}, 64'd3);
        chk("t2_beats", {32'd0, beats_sent}, 64'd4);
        chk("t2_sb_empty", sb.size(), 64'd0);
        chk("t2_done_cnt", done_cnt, 64'd1);

        // Gapped bursts
        done_cnt = 0;
        idle_run = 0;
        gaps_q.delete();
        push_run(32'h0, 2, 3);
        go(32'h0, 16'd2, 8'd3, 8'd2);
        wait_done("t3");
        cyc(2);
        chk("t3_beats", {32'd0, beats_sent}, 64'd6);
        chk("t3_sb_empty", sb.size(), 64'd0);
        chk("t3_done_cnt", done_cnt, 64'd1);
        chk("t3_num_gaps", gaps_q.size(), 64'd2);
        if (gaps_q.size() == 2) begin
            chk("t3_gap0", gaps_q[0], 64'd2);
            chk("t3_gap1", gaps_q[1], 64'd2);
        end

        // Continuous run, stop on second beat of burst 2
        done_cnt = 0;
        push_run(32'h100, 3, 2);
        go(32'h100, 16'd3, 8'd0, 8'd0);
        cyc(4);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        wait_done("t4");
        chk("t4_beats", {32'd0, beats_sent}, 64'd6);
        chk("t4_sb_empty", sb.size(), 64'd0);
        chk("t4_done_cnt", done_cnt, 64'd1);

        // start and stop together in IDLE: start wins, full run
        done_cnt = 0;
        push_run(32'h200, 2, 2);
        stop = 1'b1;
        go(32'h200, 16'd2, 8'd2, 8'd0);
        stop = 1'b0;
        wait_done("t5");
        chk("t5_beats", {32'd0, beats_sent}, 64'd4);
        chk("t5_sb_empty", sb.size(), 64'd0);

        // Asynchronous reset mid-burst
        push_run(32'h300, 2, 1);
        sb[1].last = 1'b0;
        go(32'h300, 16'd8, 8'd1, 8'd0);
        cyc(2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("t6_rst_tlast",  {63'd0, m_tlast},  64'd0);
        chk("t6_rst_busy",   {63'd0, busy},     64'd0);
        chk("t6_rst_tdata",  {32'd0, m_tdata},  64'd0);
        chk("t6_rst_beats",  {32'd0, beats_sent}, 64'd0);
        chk("t6_sb_empty", sb.size(), 64'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // burst_len=0 start is ignored
        done_cnt = 0;
        go(32'h400, 16'd0, 8'd1, 8'd0);
        cyc(5);
        chk("t7_len0_busy", {63'd0, busy}, 64'd0);
        chk("t7_len0_done", done_cnt, 64'd0);

        // start while busy is ignored
        push_run(32'h55, 3, 1);
        go(32'h55, 16'd3, 8'd1, 8'd0);
        go(32'h99, 16'd5, 8'd1, 8'd0);
        wait_done("t8");
        cyc(2);
        chk("t8_beats", {32'd0, beats_sent}, 64'd3);
        chk("t8_sb_empty", sb.size(), 64'd0);
        chk("t8_done_cnt", done_cnt, 64'd1);
        chk("t8_idle", {63'd0, busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_burst_gen.md
Name: axis_burst_gen

Overview:
- AXI-Stream transmitter that sources bursts of beats into a stream sink, such as the queue or stream_fifo under test.
- Generates a deterministic data pattern, marks burst ends with TLAST, honours backpressure, and inserts programmable idle gaps between bursts.
- Exposes beat and stall counters so benches and PMU logic can measure sink throughput.

Parameters:
- DATA_WIDTH, 32, width of m_tdata; pattern value is zero-extended or truncated to this width.
- CNT_WIDTH, 32, width of the beats_sent and stall_cycles counters.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a run; sampled only in IDLE.
- stop  input  1  graceful stop request; current burst finishes, then IDLE.
- burst_len  input  16  beats per burst; latched at start.
- num_bursts  input  8  bursts per run; 0 means run until stop; latched at start.
- gap_cycles  input  8  idle cycles between bursts; latched at start.
- seed  input  32  initial pattern value; latched at start.
- m_tvalid  output  1  AXIS valid.
- m_tready  input  1  AXIS ready from sink.
- m_tdata  output  DATA_WIDTH  AXIS data.
- m_tlast  output  1  high on the final beat of each burst.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when a run ends.
- beats_sent  output  CNT_WIDTH  handshakes completed in the current run.
- stall_cycles  output  CNT_WIDTH  cycles in the current run with m_tvalid=1 and m_tready=0.

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset, including mid-run: state=IDLE. m_tvalid, m_tlast, busy and done are 0. m_tdata, beats_sent, stall_cycles and all internal counters are 0. Any burst in progress is abandoned without completion.
- States are IDLE, SEND and GAP.
- IDLE:
  - start=1 with burst_len!=0 latches all config, loads pattern=seed, clears both counters and any pending stop, and enters SEND.
  - m_tvalid rises on the next cycle, so start-to-valid latency is 1 cycle.
  - start with burst_len=0 is ignored; no done pulse.
- SEND:
  - m_tvalid=1; m_tdata=pattern; m_tlast=1 when beat_idx==burst_len-1.
  - On handshake (m_tvalid & m_tready): beats_sent++, pattern advances, beat_idx++.
  - On a handshake with m_tlast=1: beat_idx resets and bursts_done++.
  - After the last beat, the run ends if stop is pending, or if num_bursts!=0 and bursts_done==num_bursts. Ending means going to IDLE and pulsing done in the same cycle as entering IDLE.
  - Otherwise, gap_cycles=0 goes directly to SEND, and m_tvalid stays high back-to-back with no bubble.
  - Otherwise, the block goes to GAP with gap_ctr=gap_cycles.
- GAP:
  - m_tvalid=0.
  - gap_ctr decrements each cycle; when it reaches 1 the block enters SEND.
  - This gives exactly gap_cycles idle cycles.
  - If stop is pending in GAP, the block goes to IDLE immediately and pulses done.
- AXIS rules:
  - Once m_tvalid=1 it stays high until a handshake.
  - m_tdata and m_tlast are held stable while m_tvalid=1 and m_tready=0.
  - m_tvalid never depends combinationally on m_tready.
- The pattern is continuous across bursts; it is not reloaded per burst. The default pattern is +1 per beat, wrapping modulo 2^32.
- stop:
  - Sets stop_pending in SEND or GAP; stop_pending is sticky until the run ends.
  - It never truncates a burst.
  - stop in IDLE has no effect; stop and start in the same IDLE cycle means start wins and stop is ignored.
- start while busy is ignored.
- Counters saturate at all-ones and never wrap. They hold their value in IDLE until the next accepted start.
- Outputs are registered: m_tvalid, m_tdata, m_tlast, busy and done.

Optional Feature:
- AXIS_BURST_GEN_LFSR_EN defined: the pattern advances as a 32-bit Galois LFSR with taps 0x80200003, shifting right with XOR on LSB=1. A seed of 0 is replaced by 0x00000001 at load.
- Undefined: pattern is the +1 incrementing counter. All other behaviour is identical in both builds.

Test Plan:
- Basic burst: start with burst_len=4, num_bursts=1, gap=0, seed=0x10, m_tready=1.
  -> m_tvalid on the cycle after start, then data 0x10,0x11,0x12,0x13 on consecutive cycles, m_tlast on 0x13.
  -> done pulses the cycle after 0x13; beats_sent=4, stall_cycles=0.
- Backpressure: same setup, but m_tready=0 for 3 cycles while data=0x11.
  -> data and tlast held stable throughout; stall_cycles=3; no beat dropped or duplicated.
- Gaps: burst_len=2, num_bursts=3, gap=2, seed=0.
  -> beats 0,1 | 2 idle cycles | 2,3 | 2 idle cycles | 4,5, with tlast on 1, 3 and 5.
  -> beats_sent=6 and a single done pulse.
- Continuous run plus stop: num_bursts=0, burst_len=3, gap=0, stop pulsed on the second beat of burst 2.
  -> burst 2 completes through its tlast, then done; beats_sent=6.
- Reset and illegal start: assert rst_n=0 mid-burst.
  -> all outputs 0 immediately (asynchronous).
  -> after release, start with burst_len=0 causes no activity; start while busy is ignored.
- LFSR build (AXIS_BURST_GEN_LFSR_EN, seed=0): first beats are 0x00000001, 0x80200003, then the LFSR successors per the taps.
